sap_microsequencer: RTL

Parametrised microcode sequencer for the SAP-BR control unit. It replaces the fixed combinational control ROM plus external step ring counter with one block that owns the T-state counter and a writable control store. Per instruction it variable-length sequences with an explicit end-of-instruction bit, handles conditional-jump squash from ALU flags, and latches HLT. It sits between the instruction register (opcode) and every control-line consumer in the datapath.

---
 rtl/sap_microsequencer_if.sv | 41 ++++
 rtl/sap_microsequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/sap_microsequencer_if.sv
// rtl/sap_microsequencer_if.sv - bus between the microsequencer and its datapath neighbours
//
// Purpose: groups the opcode/flag inputs, the control-store load port and the
//          control outputs of sap_microsequencer into one bundle.
// Signals:
//   opcode       instruction register opcode
//   flags        [0] carry, [1] zero from the ALU flag register
//   load_en      control-store write strobe, also stalls sequencing
//   load_addr    write address {opcode, step}
//   load_data    [CW_W] END bit, [CW_W-1:0] control word
//   control_word active control lines for the current step
//   step         current T-state
//   instr_done   high during the final step of an instruction
//   halted       sticky halt indicator
// Modports: slave = sequencer side, master = driver/datapath side.

interface sap_microsequencer_if #(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3,
  parameter int CW_W     = 18
);
  logic [OPCODE_W-1:0]        opcode;
  logic [1:0]                 flags;
  logic                       load_en;
  logic [OPCODE_W+STEP_W-1:0] load_addr;
  logic [CW_W:0]              load_data;
  logic [CW_W-1:0]            control_word;
  logic [STEP_W-1:0]          step;
  logic                       instr_done;
  logic                       halted;

  modport slave (
    input  opcode, flags, load_en, load_addr, load_data,
    output control_word, step, instr_done, halted
  );

  modport master (
    output opcode, flags, load_en, load_addr, load_data,
    input  control_word, step, instr_done, halted
  );
endinterface

// File: rtl/sap_microsequencer.sv
// rtl/sap_microsequencer.sv - microcode sequencer with writable control store for the SAP-BR control unit
//
// Purpose: owns the T-state counter and a writable control store; sequences
//          variable-length instructions (END bit or NUM_STEPS limit), squashes
//          untaken conditional jumps from the ALU flags and latches HLT.
// Ports:
//   clk  single clock, all state changes on the rising edge
//   rst  asynchronous active-high reset (step -> 0, RUN, not halted)
//   bus  sap_microsequencer_if.slave (opcode, flags, load port, control outputs)

module sap_microsequencer #(
  parameter int                   OPCODE_W  = 4,
  parameter int                   STEP_W    = 3,
  parameter int                   NUM_STEPS = 5,
  parameter int                   CW_W      = 18,
  parameter int                   HLT_BIT   = 17,
  parameter logic [OPCODE_W-1:0]  JC_OPCODE = 4'b0111,
  parameter logic [OPCODE_W-1:0]  JZ_OPCODE = 4'b1000,
  parameter int                   COND_STEP = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  sap_microsequencer_if.slave  bus
);

  localparam int ADDR_W = OPCODE_W + STEP_W;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
  localparam logic [STEP_W-1:0] COND_AT   = STEP_W'(COND_STEP);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;

  // Control store: {END, control word} per {opcode, step}. Deliberately not
  // reset; software loads it before releasing the CPU.
  logic [CW_W:0] store [DEPTH];
  logic [CW_W:0] rd_word;

  always_ff @(posedge clk) begin
    if (bus.load_en) begin
      store[bus.load_addr] <= bus.load_data;
    end
  end

  // Asynchronous read: a write at an edge is visible only after that edge.
  assign rd_word = store[{bus.opcode, step_q}];

  // Decode of the current step.
  logic is_cond_step;
  logic squash;
  logic word_end;
  logic word_hlt;
  logic last;

  assign is_cond_step = (step_q == COND_AT);

  // An untaken conditional jump kills its own control word and ends the
  // instruction at the condition step.
  assign squash = is_cond_step &&
                  (((bus.opcode == JC_OPCODE) && !bus.flags[0]) ||
                   ((bus.opcode == JZ_OPCODE) && !bus.flags[1]));

  assign word_end = rd_word[CW_W];
  assign word_hlt = rd_word[HLT_BIT];

  // The NUM_STEPS bound keeps step inside the legal range even if no END bit
  // was loaded for this opcode.
  assign last = word_end || (step_q == LAST_STEP) || squash;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Next-state logic. A load stall takes priority over everything so a HLT
  // word being written (or read) during a load never halts until load_en drops.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_RUN: begin
        if (bus.load_en) begin
          step_d = step_q;
        end else if (word_hlt && !squash) begin
          state_d = S_HALT;
          step_d  = step_q;
        end else if (last) begin
          step_d = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_HALT: begin
        // Only rst leaves HALT; step stays frozen for inspection.
        state_d = S_HALT;
        step_d  = step_q;
      end
      default: begin
        state_d = S_RUN;
        step_d  = '0;
      end
    endcase
  end

  // Output logic.
  logic halted_w;

  always_comb begin
    halted_w         = (state_q == S_HALT);
    bus.halted       = halted_w;
    bus.step         = step_q;
    bus.control_word = (halted_w || bus.load_en || squash) ? '0 : rd_word[CW_W-1:0];
    bus.instr_done   = last && !halted_w && !bus.load_en;
  end

  // Step must never leave the configured instruction length.
  a_step_bound: assert property (@(posedge clk) disable iff (rst) step_q <= LAST_STEP);

endmodule
